// File: rtl/pc_sequencer_if.sv
// Bundle between the fetch/branch sequencer and its decode, ALU, PC and test-harness neighbours.
// start is level-sampled in IDLE/HALT; done stays high for every HALT cycle until start is seen.
interface pc_sequencer_if #(
  parameter int D  = 10,
  parameter int LW = 4,
  parameter int CW = 16
);
  logic          start;
  logic          halt_req;
  logic          branch_req;
  logic          branch_taken;
  logic [LW-1:0] branch_idx;
  logic [D-1:0]  pc_in;
  logic          cfg_we;
  logic [LW-1:0] cfg_idx;
  logic [D-1:0]  cfg_data;
  logic          pc_reset;
  logic          pc_jump_en;
  logic [D-1:0]  pc_jump_target;
  logic          instr_valid;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;
  logic [1:0]    fsm_state;

  modport master (
    input  start, halt_req, branch_req, branch_taken, branch_idx, pc_in,
           cfg_we, cfg_idx, cfg_data,
    output pc_reset, pc_jump_en, pc_jump_target, instr_valid, done, timeout,
           cycle_cnt, fsm_state
  );

  modport slave (
    output start, halt_req, branch_req, branch_taken, branch_idx, pc_in,
           cfg_we, cfg_idx, cfg_data,
    input  pc_reset, pc_jump_en, pc_jump_target, instr_valid, done, timeout,
           cycle_cnt, fsm_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/branch controller: drives PC reset/jump from branch and halt requests, resolving
// branch targets through a runtime-writable LUT, with a one-cycle flush after taken branches.
module pc_sequencer #(
  parameter int D       = 10,
  parameter int LW      = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic [D-1:0]  lut [2**LW];
  logic          tmo_hit;
  logic          active;
  logic [CW-1:0] cnt_inc;

  assign active  = (state == RUN) || (state == FLUSH);
  assign tmo_hit = active && (cnt == CW'(TIMEOUT - 1));
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  // Reset image places entry i at the top LW bits so each index maps to a distinct code region.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**LW; i++) begin
        lut[i] <= {LW'(i), {(D-LW){1'b0}}};
      end
    end else if (bus.cfg_we) begin
      lut[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
            tmo   <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (tmo_hit) begin
            state <= HALT;
            tmo   <= 1'b1;
          end else if (bus.halt_req) begin
            state <= HALT;
          end else if (bus.branch_req && bus.branch_taken) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          cnt <= cnt_inc;
          if (tmo_hit) begin
            state <= HALT;
            tmo   <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        HALT: begin
          if (bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Jumping to pc_in is how the PC is frozen on halt/timeout.
  always_comb begin
    bus.pc_reset       = 1'b0;
    bus.pc_jump_en     = 1'b0;
    bus.pc_jump_target = '0;
    bus.instr_valid    = 1'b0;
    bus.done           = 1'b0;
    case (state)
      IDLE: begin
        bus.pc_reset = 1'b1;
      end
      RUN: begin
        bus.instr_valid = 1'b1;
        if (tmo_hit || bus.halt_req) begin
          bus.pc_jump_en     = 1'b1;
          bus.pc_jump_target = bus.pc_in;
        end else if (bus.branch_req && bus.branch_taken) begin
          bus.pc_jump_en     = 1'b1;
          bus.pc_jump_target = lut[bus.branch_idx];
        end
      end
      FLUSH: begin
        if (tmo_hit) begin
          bus.pc_jump_en     = 1'b1;
          bus.pc_jump_target = bus.pc_in;
        end
      end
      HALT: begin
        bus.done           = 1'b1;
        bus.pc_jump_en     = 1'b1;
        bus.pc_jump_target = bus.pc_in;
      end
      default: begin
        bus.pc_reset = 1'b1;
      end
    endcase
  end

  assign bus.cycle_cnt = cnt;
  assign bus.timeout   = tmo;
  assign bus.fsm_state = state;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/branch controller that drives the program counter's control inputs (reset, absolute-jump enable, jump target) from decode/ALU branch requests.
Owns a 16-entry, runtime-writable jump-target LUT that resolves a 4-bit branch index to a full D-bit absolute target.
Sequences the run lifecycle (idle → run → halt/done) with a start/done handshake to the testbench.
Inserts one flush bubble after every taken branch to kill the wrong-path instruction from the synchronous instruction memory.

Parameters:
D, 10, program-counter / target width
LW, 4, LUT index width (2**LW entries)
CW, 16, cycle-counter width
TIMEOUT, 4096, cycle limit before forced halt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  testbench start; level-sampled
halt_req  in  1  decode: current instruction is HALT
branch_req  in  1  decode: current instruction is a branch
branch_taken  in  1  ALU condition for current branch
branch_idx  in  LW  LUT index for current branch
pc_in  in  D  current prog_ctr value from PC
cfg_we  in  1  LUT write enable
cfg_idx  in  LW  LUT write index
cfg_data  in  D  LUT write data
pc_reset  out  1  drives PC reset
pc_jump_en  out  1  drives PC absolute-jump enable
pc_jump_target  out  D  drives PC target (already LUT-resolved)
instr_valid  out  1  instruction at decode is live (not a bubble)
done  out  1  program finished
timeout  out  1  halt was forced by TIMEOUT
cycle_cnt  out  CW  cycles spent in RUN+FLUSH

Behaviour:
- States: IDLE, RUN, FLUSH, HALT. Registered state; all control outputs are combinational from state and inputs. cycle_cnt and timeout are registered.
- Reset (any state, mid-run included):
  - state=IDLE, cycle_cnt=0, timeout=0.
  - LUT entry i = {i, (D-LW) zeros}, e.g. entry 3 = 10'b0011000000.
- IDLE: pc_reset=1, pc_jump_en=0, pc_jump_target=0, instr_valid=0, done=0.
  - start=1 → RUN next cycle and cycle_cnt cleared to 0.
- RUN: pc_reset=0, instr_valid=1. Priority is timeout > halt_req > taken branch > sequential.
  - cycle_cnt==TIMEOUT-1: pc_jump_en=1, target=pc_in, next HALT, timeout<=1.
  - halt_req: pc_jump_en=1, target=pc_in (freeze), next HALT.
  - branch_req & branch_taken: pc_jump_en=1, target=LUT[branch_idx], next FLUSH.
  - branch_req & !branch_taken: pc_jump_en=0, stay RUN.
  - Otherwise: pc_jump_en=0 (PC increments), stay RUN.
- FLUSH: exactly one cycle, always → RUN.
  - instr_valid=0, pc_jump_en=0; halt_req and branch_req are ignored.
  - The timeout check still applies and takes priority.
- HALT: done=1, instr_valid=0, pc_jump_en=1, target=pc_in, so PC holds.
  - start=1 → IDLE. If start is still high in IDLE, the next cycle enters RUN (restart).
- cycle_cnt: +1 every cycle in RUN or FLUSH; holds in HALT/IDLE; saturates at all-ones.
- timeout: cleared on the IDLE→RUN transition.
- LUT write:
  - Accepted in any state except the reset cycle; visible starting the next cycle.
  - Same-cycle write and read of the same index returns the old value.
  - Writes in the reset cycle are discarded.
- Branch index out of range is not possible: width is LW and the LUT is fully populated.

Test Plan:
- Reset then start=1 for 1 cycle, no requests for 5 cycles → pc_reset=1 in IDLE then 0; pc_jump_en=0 throughout; instr_valid=1; cycle_cnt=5; done=0.
- In RUN, branch_req=1, taken=1, idx=3 with default LUT → pc_jump_en=1, target=10'd192 that cycle; next cycle FLUSH with instr_valid=0; following cycle RUN, instr_valid=1.
- cfg_we=1, idx=3, data=10'd37, with a same-cycle branch on idx 3 → target=192; a branch on idx 3 in a later cycle → target=37.
- branch_req=1, taken=0 → pc_jump_en=0, no FLUSH. Same cycle as halt_req=1 with taken=1 → halt wins: target=pc_in, next HALT, done=1.
- TIMEOUT=8, no halt → at cycle_cnt=7 force HALT; timeout=1, done=1; pc_jump_target tracks pc_in. Then start=1 → IDLE, start held → RUN, timeout=0, cycle_cnt=0.
- Reset asserted in FLUSH after LUT[3] rewritten → next cycle IDLE, done=0, cycle_cnt=0, LUT[3]=192 again.
